// File: rtl/tdm_demux4.sv
// 4-slot TDM demultiplexer with frame-sync acquisition.
// Slots are gathered into shadow registers, and a complete frame is copied
// to out0..out3 in one step on the slot-3 sample. A partial frame never
// reaches the outputs. The frame loses lock when fsync is missing at slot 0.
module tdm_demux4 #(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         en,
    input  logic         fsync,
    input  logic [W-1:0] din,
    output logic [W-1:0] out0,
    output logic [W-1:0] out1,
    output logic [W-1:0] out2,
    output logic [W-1:0] out3,
    output logic         frame_valid,
    output logic         sync_err,
    output logic         locked,
    output logic [1:0]   slot
);

    typedef enum logic {
        HUNT = 1'b0,
        RUN  = 1'b1
    } state_t;

    state_t       state;
    logic [1:0]   slot_reg;
    logic [3:0]   sh_we;
    logic         frame_done;
    logic [W-1:0] sh      [4];
    logic [W-1:0] out_reg [4];

    // A frame completes on a plain (no fsync) sample taken at slot 3 while framed.
    assign frame_done = en && (state == RUN) && !fsync && (slot_reg == 2'd3);

    // Framing FSM: owns the lock state, the slot counter and the status pulses.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= HUNT;
            slot_reg    <= 2'd0;
            frame_valid <= 1'b0;
            sync_err    <= 1'b0;
            locked      <= 1'b0;
        end else begin
            frame_valid <= 1'b0;
            sync_err    <= 1'b0;
            if (en) begin
                case (state)
                    HUNT: begin
                        if (fsync) begin
                            state    <= RUN;
                            slot_reg <= 2'd1;
                            locked   <= 1'b1;
                        end
                    end
                    RUN: begin
                        if (fsync) begin
                            // fsync at slot 0 is normal; elsewhere it restarts the frame
                            sync_err <= (slot_reg != 2'd0);
                            slot_reg <= 2'd1;
                        end else if (slot_reg == 2'd0) begin
                            // expected fsync did not arrive: drop lock
                            sync_err <= 1'b1;
                            state    <= HUNT;
                            locked   <= 1'b0;
                        end else begin
                            slot_reg    <= slot_reg + 2'd1;
                            frame_valid <= (slot_reg == 2'd3);
                        end
                    end
                    default: begin
                        state    <= HUNT;
                        slot_reg <= 2'd0;
                        locked   <= 1'b0;
                    end
                endcase
            end
        end
    end

    genvar gi;
    generate
        for (gi = 0; gi < 4; gi++) begin : g_slot
            if (gi == 0) begin : g_we0
                // slot 0 is loaded by any fsync sample, in either state
                assign sh_we[gi] = en && fsync;
            end else begin : g_wen
                assign sh_we[gi] = en && !fsync && (state == RUN) && (slot_reg == 2'(gi));
            end

            // Shadow register for this slot; holds the partial frame being assembled.
            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    sh[gi] <= '0;
                end else if (sh_we[gi]) begin
                    sh[gi] <= din;
                end
            end

            // Output register: loads only when a whole frame has been gathered.
            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    out_reg[gi] <= '0;
                end else if (frame_done) begin
                    if (gi == 3) begin
                        out_reg[gi] <= din;
                    end else begin
                        out_reg[gi] <= sh[gi];
                    end
                end
            end
        end
    endgenerate

    assign out0 = out_reg[0];
    assign out1 = out_reg[1];
    assign out2 = out_reg[2];
    assign out3 = out_reg[3];
    assign slot = slot_reg;

endmodule

// File: doc/tdm_demux4.md
TDM_DEMUX4 -- requirements
Module: tdm_demux4

Interface
REQ-001 SHALL have parameter W, default 8, meaning data width of one time slot.
REQ-002 SHALL have port clk  input  1  rising-edge clock for all state.
REQ-003 SHALL have port rst_n  input  1  reset, asynchronous and active-low.
REQ-004 SHALL have port en  input  1  sample strobe; din and fsync are ignored when low.
REQ-005 SHALL have port fsync  input  1  frame sync; marks the sample carrying slot 0.
REQ-006 SHALL have port din  input  W  TDM slot data.
REQ-007 SHALL have ports out0, out1, out2, out3  output  W each  registered channel data for slots 0..3.
REQ-008 SHALL have port frame_valid  output  1  one-cycle pulse when out0..out3 take a new complete frame.
REQ-009 SHALL have port sync_err  output  1  one-cycle pulse on a framing violation.
REQ-010 SHALL have port locked  output  1  high while in state RUN.
REQ-011 SHALL have port slot  output  2  index of the next slot to be captured.

Function
REQ-012 SHALL implement two states: HUNT (not framed) and RUN (framed).
REQ-013 SHALL hold a 2-bit slot counter and four W-bit shadow registers, sh0..sh3.
REQ-014 SHALL leave all state unchanged on cycles with en=0; frame_valid and sync_err are 0 on those cycles.
REQ-015 In HUNT with en=1, fsync=0: SHALL discard din and stay in HUNT.
REQ-016 In HUNT with en=1, fsync=1: SHALL write din to sh0, set slot=1, and go to RUN.
REQ-017 In RUN with en=1, fsync=0, slot!=0: SHALL write din to sh[slot] and increment slot.
REQ-018 In RUN, on an en=1 sample at slot=3, SHALL update out0..out2 from sh0..sh2 and out3 from din on the same clock edge; slot wraps to 0.
- Capture-to-output latency: 1 clock.
REQ-019 frame_valid SHALL be high for exactly the cycle following the slot-3 sample edge.
REQ-020 out0..out3 SHALL update only as a complete frame; partial frames never reach the outputs.
REQ-021 In RUN, en=1, fsync=1 with slot!=0 (early sync), SHALL:
- pulse sync_err;
- discard the partial frame;
- write din to sh0 and set slot=1;
- stay in RUN.
REQ-022 In RUN, en=1, fsync=0 with slot=0 (missing sync), SHALL:
- pulse sync_err;
- discard din;
- go to HUNT.
REQ-023 In RUN, en=1, fsync=1 with slot=0 SHALL be treated as normal slot-0 capture.
REQ-024 sync_err and frame_valid SHALL never assert in the same cycle.
REQ-025 In HUNT, slot SHALL read 0.
REQ-026 out0..out3 SHALL keep their last valid frame through sync_err and HUNT.

Reset
REQ-027 While rst_n=0, SHALL force:
- state HUNT, slot=0;
- sh0..sh3=0, out0..out3=0;
- frame_valid=0, sync_err=0, locked=0.
REQ-028 Reset assertion SHALL take effect immediately, without waiting for clk, including mid-frame; the partial frame is lost.
REQ-029 After rst_n rises, operation SHALL begin at the first clk edge where en=1.

Verification
REQ-030 Reset mid-frame (after slots 0,1 captured): all outputs 0 at once, locked=0; the next good frame is delivered normally.
REQ-031 Sync acquire, W=8: en=1 continuous, fsync with slot 0, din=11,22,33,44 -> one cycle after the 44 sample, out0..out3=11,22,33,44, frame_valid=1 for one cycle, locked=1 from the cycle after the 11 sample.
REQ-032 Gapped en: same frame with en=0 for 3 cycles between each sample -> same outputs, and a single frame_valid pulse only after the slot-3 sample.
REQ-033 Early sync: fsync asserted at slot 2 -> sync_err for one cycle, locked stays 1, out0..out3 unchanged, slot=1 next; the following 3 samples complete a frame.
REQ-034 Missing sync: after a complete frame, next en sample has fsync=0 -> sync_err for one cycle, locked=0, slot=0; samples without fsync are ignored until fsync returns.
REQ-035 Back-to-back frames AA..DD then 01..04 with no gap -> two frame_valid pulses 4 samples apart, and out0..out3 switch atomically between frames.
